pad_output_ctrl: RTL and testbench
==================================

Name: pad_output_ctrl

Overview:
- Per-pad output control stage directly upstream of the simulation/ASIC output pad cell; drives its pad_in_i, pad_oe_i and pad_attributes_i.
- Selects one of NSRC peripheral output sources and applies pad attribute updates without glitching the pad.
- Every source switch or attribute change goes through a break-before-make turnaround: output-enable is forced low for TURN_CYCLES before the new configuration takes effect.

Parameters:
- NSRC, 4, number of selectable peripheral sources (>=2).
- PADATTR, 16, pad attribute width; 0 is treated as 1 (PADATTR_RND).
- TURN_CYCLES, 2, oe-low cycles inserted on switch or attribute change (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- src_out_i  in  NSRC  per-source output value
- src_oe_i  in  NSRC  per-source output enable
- sel_i  in  $clog2(NSRC)  requested source index
- attr_req_i  in  1  attribute update request
- attr_i  in  PADATTR_RND  new attribute value
- attr_gnt_o  out  1  one-cycle pulse: attribute applied
- busy_o  out  1  turnaround in progress
- pad_in_o  out  1  to pad cell pad_in_i
- pad_oe_o  out  1  to pad cell pad_oe_i
- pad_attributes_o  out  PADATTR_RND  to pad cell pad_attributes_i

Behaviour:
- Reset (async assert, sync release): cur_sel=0, attr_q=0, FSM=ACTIVE, cnt=0, pad_in_o=0, pad_oe_o=0, attr_gnt_o=0, busy_o=0.
- State ACTIVE: pad_in_o=src_out_i[cur_sel], pad_oe_o=src_oe_i[cur_sel]. busy_o=0.
  - Pending event = (sel_i != cur_sel) or attr_req_i.
  - Fast path: if pad_oe_o would be 0 this cycle, the event applies on the same clock edge without turnaround (cur_sel<=sel_i, attr_q<=attr_i if req, attr_gnt_o pulses next cycle if req).
  - Otherwise -> DRAIN, cnt<=TURN_CYCLES-1; latch next_sel<=sel_i, next_attr<=attr_i, next_req<=attr_req_i.
- State DRAIN: pad_oe_o=0, pad_in_o holds the last driven value, busy_o=1. cnt decrements; at cnt==0 -> APPLY.
- State APPLY (1 cycle): pad_oe_o=0; cur_sel<=next_sel; attr_q<=next_attr if next_req; attr_gnt_o=1 in this cycle if next_req; -> ACTIVE.
- Total oe-low window on the slow path = TURN_CYCLES+1 cycles.
- attr_req_i is level-held by the requester until attr_gnt_o. Requests are not accepted while busy_o=1; sel_i changes during DRAIN/APPLY are ignored until back in ACTIVE, then handled as a new event.
- Simultaneous sel change and attr_req: one turnaround applies both; a single gnt.
- sel_i >= NSRC: treated as no change (ignored).
- pad_attributes_o = attr_q always; it changes only in APPLY or on the fast path (oe already 0).
- Reset mid-DRAIN: pending request dropped, no gnt, outputs to reset values.

Optional Feature:
- Macro: PAD_OUTPUT_CTRL_REG_OUT_EN.
- Defined: pad_in_o and pad_oe_o are registered (flop after mux/FSM gating). +1 cycle latency from src_*_i to the pad; reset value 0. The oe-low window is shifted one cycle but keeps the same length.
- Undefined: both are combinational from src_*_i and FSM state; zero latency.

Test Plan:
- Reset: assert rst_i mid-run -> all outputs 0 immediately (asynchronous); after release cur_sel=0, attributes 0.
- Passthrough: sel=0, src_oe_i=4'b0001, toggle src_out_i[0] -> pad_in_o follows with 0 cycles latency (1 with the macro defined), pad_oe_o=1.
- Switch with oe high: sel_i 0->2 while src_oe_i[0]=1, TURN_CYCLES=2 -> pad_oe_o=0 for exactly 3 cycles, busy_o=1 for 3 cycles, then pad follows src 2.
- Attribute fast path: pad_oe_o=0, attr_req_i=1 with attr_i=16'hA5A5 -> pad_attributes_o=16'hA5A5 next cycle, one gnt pulse, busy_o stays 0.
- Combined event: sel 1->3 and attr_req_i=1 (attr_i=16'h0F0F) in the same cycle, oe high -> a single turnaround, one gnt in the APPLY cycle, both changes visible on return to ACTIVE.
- Reset during DRAIN: rst_i pulse at cnt=1 -> no gnt, attributes remain 0, FSM=ACTIVE.

Source files
------------

// File: rtl/pad_output_ctrl.sv
// pad_output_ctrl: source select and attribute stage feeding one output pad cell.
// Every switch of a driving source goes through a break-before-make oe-low turnaround.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   src_out_i/src_oe_i  per-source output value and output enable
//   sel_i               requested source (indices >= NSRC are ignored)
//   attr_req_i/attr_i   level-held attribute update request and its value
//   attr_gnt_o          one-cycle pulse when the attribute is applied
//   busy_o              turnaround in progress
//   pad_in_o, pad_oe_o, pad_attributes_o  to the pad cell
//
// Build option PAD_OUTPUT_CTRL_REG_OUT_EN: when defined, pad_in_o and
// pad_oe_o are registered (+1 cycle latency, reset value 0).
module pad_output_ctrl #(
  parameter int NSRC = 4,
  parameter int PADATTR = 16,
  parameter int TURN_CYCLES = 2,
  localparam int PADATTR_RND = (PADATTR == 0) ? 1 : PADATTR,
  localparam int SELW = $clog2(NSRC),
  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NSRC-1:0]        src_out_i,
  input  logic [NSRC-1:0]        src_oe_i,
  input  logic [SELW-1:0]        sel_i,
  input  logic                   attr_req_i,
  input  logic [PADATTR_RND-1:0] attr_i,
  output logic                   attr_gnt_o,
  output logic                   busy_o,
  output logic                   pad_in_o,
  output logic                   pad_oe_o,
  output logic [PADATTR_RND-1:0] pad_attributes_o
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SELW-1:0]        cur_sel, next_sel, sel_new;
  logic [PADATTR_RND-1:0] attr_q, next_attr;
  logic                   next_req;
  logic [CW-1:0]          cnt_q;
  logic                   last_in_q;
  logic                   gnt_fast_q;

  logic mux_in, mux_oe;
  logic sel_ok, sel_chg, req_eff, evt;
  logic core_in, core_oe;
  logic busy, gnt_apply, fast, start;

  assign sel_ok = (32'(sel_i) < NSRC);

  always_comb begin
    mux_in  = src_out_i[cur_sel];
    mux_oe  = src_oe_i[cur_sel];
    sel_chg = sel_ok && (sel_i != cur_sel);
    // The requester still holds req during the fast-path gnt cycle.
    req_eff = attr_req_i && !gnt_fast_q;
    evt     = sel_chg || req_eff;
    sel_new = sel_chg ? sel_i : cur_sel;

    state_d   = state_q;
    core_in   = last_in_q;
    core_oe   = 1'b0;
    busy      = 1'b0;
    gnt_apply = 1'b0;
    fast      = 1'b0;
    start     = 1'b0;

    unique case (state_q)
      ACTIVE: begin
        core_in = mux_in;
        core_oe = mux_oe;
        if (evt) begin
          if (mux_oe) begin
            start   = 1'b1;
            state_d = DRAIN;
          end else begin
            fast = 1'b1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = APPLY;
      end
      APPLY: begin
        busy      = 1'b1;
        gnt_apply = next_req;
        state_d   = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ACTIVE;
      cur_sel    <= '0;
      attr_q     <= '0;
      next_sel   <= '0;
      next_attr  <= '0;
      next_req   <= 1'b0;
      cnt_q      <= '0;
      last_in_q  <= 1'b0;
      gnt_fast_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_fast_q <= fast && req_eff;
      if (state_q == ACTIVE) last_in_q <= mux_in;
      if (fast) begin
        cur_sel <= sel_new;
        if (req_eff) attr_q <= attr_i;
      end
      if (start) begin
        next_sel  <= sel_new;
        next_attr <= attr_i;
        next_req  <= req_eff;
        cnt_q     <= CW'(TURN_CYCLES - 1);
      end
      if (state_q == DRAIN && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (state_q == APPLY) begin
        cur_sel  <= next_sel;
        if (next_req) attr_q <= next_attr;
        next_req <= 1'b0;
      end
    end
  end

  assign attr_gnt_o       = gnt_fast_q | gnt_apply;
  assign busy_o           = busy;
  assign pad_attributes_o = attr_q;

`ifdef PAD_OUTPUT_CTRL_REG_OUT_EN
  logic pad_in_q, pad_oe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_in_q <= 1'b0;
      pad_oe_q <= 1'b0;
    end else begin
      pad_in_q <= core_in;
      pad_oe_q <= core_oe;
    end
  end

  assign pad_in_o = pad_in_q;
  assign pad_oe_o = pad_oe_q;
`else
  // Held at 0 while reset is asserted, independent of the sources.
  assign pad_in_o = core_in & ~rst_i;
  assign pad_oe_o = core_oe & ~rst_i;
`endif

endmodule

// File: tb/tb_pad_output_ctrl.sv
// tb_pad_output_ctrl: directed and random stimulus against a cycle model
// of the pad output controller.
module tb_pad_output_ctrl;
  localparam int NSRC = 4;
  localparam int PADATTR = 16;
  localparam int TURN = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  src_out_i, src_oe_i;
  logic [1:0]  sel_i;
  logic        attr_req_i;
  logic [15:0] attr_i;
  logic        attr_gnt_o, busy_o, pad_in_o, pad_oe_o;
  logic [15:0] pad_attributes_o;

  pad_output_ctrl #(
    .NSRC(NSRC), .PADATTR(PADATTR), .TURN_CYCLES(TURN)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .src_out_i(src_out_i), .src_oe_i(src_oe_i),
    .sel_i(sel_i), .attr_req_i(attr_req_i), .attr_i(attr_i),
    .attr_gnt_o(attr_gnt_o), .busy_o(busy_o),
    .pad_in_o(pad_in_o), .pad_oe_o(pad_oe_o),
    .pad_attributes_o(pad_attributes_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: selection, attributes, and remaining oe-low window length.
  int          m_sel, m_nsel, m_win;
  logic [15:0] m_attr, m_nattr;
  bit          m_nreq, m_gfast, m_last;
  bit          p_in, p_oe;
  bit          last_gnt;
  int          c_lo, c_busy, c_gnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_nsel = 0; m_win = 0;
    m_attr = '0; m_nattr = '0;
    m_nreq = 0; m_gfast = 0; m_last = 0;
    p_in = 0; p_oe = 0; last_gnt = 0;
  endtask

  task automatic cyc();
    bit ein, eoe, ebusy, egnt, req, chg;
    bit xin, xoe;
    @(negedge clk);
    if (m_win == 0) begin
      ein = src_out_i[m_sel];
      eoe = src_oe_i[m_sel];
      ebusy = 0;
      egnt = m_gfast;
    end else begin
      ein = m_last;
      eoe = 0;
      ebusy = 1;
      egnt = (m_win == 1) && m_nreq;
    end
`ifdef PAD_OUTPUT_CTRL_REG_OUT_EN
    xin = p_in; xoe = p_oe;
    p_in = ein; p_oe = eoe;
`else
    xin = ein; xoe = eoe;
`endif
    check("pad_in", 32'(pad_in_o), 32'(xin));
    check("pad_oe", 32'(pad_oe_o), 32'(xoe));
    check("busy", 32'(busy_o), 32'(ebusy));
    check("gnt", 32'(attr_gnt_o), 32'(egnt));
    check("attr", 32'(pad_attributes_o), 32'(m_attr));
    c_lo   += int'(!pad_oe_o);
    c_busy += int'(busy_o);
    c_gnt  += int'(attr_gnt_o);
    last_gnt = egnt;
    if (m_win == 0) begin
      m_last = ein;
      req = attr_req_i && !egnt;
      chg = (int'(sel_i) < NSRC) && (int'(sel_i) != m_sel);
      m_gfast = 0;
      if (chg || req) begin
        if (!src_oe_i[m_sel]) begin
          if (chg) m_sel = int'(sel_i);
          if (req) begin
            m_attr = attr_i;
            m_gfast = 1;
          end
        end else begin
          m_win = TURN + 1;
          m_nsel = chg ? int'(sel_i) : m_sel;
          m_nattr = attr_i;
          m_nreq = req;
        end
      end
    end else begin
      if (m_win == 1) begin
        m_sel = m_nsel;
        if (m_nreq) m_attr = m_nattr;
        m_nreq = 0;
      end
      m_win--;
      m_gfast = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    c_lo = 0; c_busy = 0; c_gnt = 0;
  endtask

  // Called 1 time unit after a rising edge.
  task automatic do_reset();
    rst_i = 1'b1;
    attr_req_i = 1'b0;
    #1;
    check("rst_pad_in", 32'(pad_in_o), 0);
    check("rst_pad_oe", 32'(pad_oe_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_gnt", 32'(attr_gnt_o), 0);
    check("rst_attr", 32'(pad_attributes_o), 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    rst_i = 1'b1;
    src_out_i = 4'hF;
    src_oe_i = 4'hF;
    sel_i = 2'd0;
    attr_req_i = 1'b0;
    attr_i = '0;
    clr_cnt();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_pad_in", 32'(pad_in_o), 0);
    check("init_pad_oe", 32'(pad_oe_o), 0);
    check("init_attr", 32'(pad_attributes_o), 0);
    rst_i = 1'b0;
    src_out_i = '0;
    src_oe_i = '0;
    cyc();

    // Passthrough on source 0.
    src_oe_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      src_out_i = {3'b000, i[0]};
      cyc();
    end

    // Switch 0 -> 2 with oe high.
    src_oe_i = 4'b0101;
    src_out_i = 4'b0100;
    sel_i = 2'd2;
    clr_cnt();
    repeat (6) cyc();
    check("sw_oe_low_cycles", c_lo, 3);
    check("sw_busy_cycles", c_busy, 3);
    src_out_i = 4'b0000;
    cyc();
    src_out_i = 4'b0100;
    cyc();

    // Attribute fast path with oe low.
    src_oe_i = 4'b0000;
    attr_req_i = 1'b1;
    attr_i = 16'hA5A5;
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (last_gnt) attr_req_i = 1'b0;
    end
    check("fast_attr", 32'(pad_attributes_o), 32'h0000A5A5);
    check("fast_gnt_count", c_gnt, 1);
    check("fast_busy_cycles", c_busy, 0);

    // Fast source move to 1, then combined sel 1 -> 3 plus attribute.
    sel_i = 2'd1;
    cyc();
    src_oe_i = 4'b1010;
    src_out_i = 4'b1000;
    sel_i = 2'd3;
    attr_req_i = 1'b1;
    attr_i = 16'h0F0F;
    clr_cnt();
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (last_gnt) attr_req_i = 1'b0;
    end
    check("comb_gnt_count", c_gnt, 1);
    check("comb_busy_cycles", c_busy, 3);
    check("comb_attr", 32'(pad_attributes_o), 32'h00000F0F);
    check("comb_pad_oe", 32'(pad_oe_o), 1);
    check("comb_pad_in", 32'(pad_in_o), 1);

    // Reset while draining (cnt = 1).
    src_oe_i = 4'b1111;
    sel_i = 2'd0;
    attr_req_i = 1'b1;
    attr_i = 16'h1234;
    cyc();
    check("drain_busy", 32'(busy_o), 1);
    do_reset();
    clr_cnt();
    repeat (4) cyc();
    check("rdrain_gnt_count", c_gnt, 0);
    check("rdrain_busy", c_busy, 0);
    check("rdrain_attr", 32'(pad_attributes_o), 0);

    // Random traffic with a level-holding requester.
    for (int i = 0; i < 400; i++) begin
      src_out_i = 4'($urandom);
      src_oe_i = 4'($urandom);
      if ($urandom_range(0, 5) == 0) sel_i = 2'($urandom);
      if (last_gnt) attr_req_i = 1'b0;
      else if (!attr_req_i && $urandom_range(0, 5) == 0) begin
        attr_req_i = 1'b1;
        attr_i = 16'($urandom);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
